// File: rtl/alu_ctrl_idex.sv
// ID-stage ALUCode/control decoder feeding the ID/EX pipeline register, plus an illegal-op counter.
// Latency: 1 cycle id_instr -> ex_*; per edge flush (bubble) beats stall (hold) beats load.
module alu_ctrl_idex #(
    parameter int ILL_CNT_W = 8,
    parameter int LUI_SHAMT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          id_instr,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic [4:0]           ex_alu_code,
    output logic [1:0]           ex_src_a,
    output logic                 ex_src_b,
    output logic [31:0]          ex_imm,
    output logic [4:0]           ex_shamt,
    output logic [4:0]           ex_dst,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_valid,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_AND  = 5'b00001, ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011, ALU_NOR  = 5'b00100, ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_ANDI = 5'b00110, ALU_XORI = 5'b00111, ALU_ORI  = 5'b01000;
    localparam logic [4:0] ALU_JR   = 5'b01001, ALU_BEQ  = 5'b01010, ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_BGEZ = 5'b01100, ALU_BGTZ = 5'b01101, ALU_BLEZ = 5'b01110;
    localparam logic [4:0] ALU_BLTZ = 5'b01111, ALU_SLL  = 5'b10000, ALU_SRL  = 5'b10001;
    localparam logic [4:0] ALU_SRA  = 5'b10010, ALU_SLT  = 5'b10011, ALU_SLTU = 5'b10100;
    localparam logic [4:0] ALU_ADDU = 5'b10101, ALU_SUBU = 5'b10110;

    // src_a = 2 selects LUI_SHAMT in the EX operand mux, so it must fit a 5-bit shift.
    if (LUI_SHAMT < 0 || LUI_SHAMT > 31) begin : g_bad_lui_shamt
        $error("LUI_SHAMT must fit a 5-bit shift amount");
    end

    typedef struct packed {
        logic [4:0]  alu_code;
        logic [1:0]  src_a;
        logic        src_b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        valid;
        logic        illegal;
    } ex_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_rs;

    assign op        = id_instr[31:26];
    assign funct     = id_instr[5:0];
    assign rt        = id_instr[20:16];
    assign rd        = id_instr[15:11];
    assign unused_rs = ^id_instr[25:21];

    ex_t dec;
    ex_t ex_d, ex_q;
    logic [ILL_CNT_W-1:0] ill_d, ill_q;

    // dst is only driven for instructions that write back; non-writers carry 0.
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.imm       = {{16{id_instr[15]}}, id_instr[15:0]};
        dec.shamt     = id_instr[10:6];
        unique case (op)
            6'h00: begin
                dec.dst       = rd;
                dec.reg_write = 1'b1;
                case (funct)
                    6'h20: dec.alu_code = ALU_ADD;
                    6'h21: dec.alu_code = ALU_ADDU;
                    6'h22: dec.alu_code = ALU_SUB;
                    6'h23: dec.alu_code = ALU_SUBU;
                    6'h24: dec.alu_code = ALU_AND;
                    6'h25: dec.alu_code = ALU_OR;
                    6'h26: dec.alu_code = ALU_XOR;
                    6'h27: dec.alu_code = ALU_NOR;
                    6'h2A: dec.alu_code = ALU_SLT;
                    6'h2B: dec.alu_code = ALU_SLTU;
                    6'h00: begin dec.alu_code = ALU_SLL; dec.src_a = 2'd1; end
                    6'h02: begin dec.alu_code = ALU_SRL; dec.src_a = 2'd1; end
                    6'h03: begin dec.alu_code = ALU_SRA; dec.src_a = 2'd1; end
                    6'h08: begin
                        dec.alu_code  = ALU_JR;
                        dec.branch    = 1'b1;
                        dec.reg_write = 1'b0;
                        dec.dst       = '0;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec.src_b     = 1'b1;
                dec.dst       = rt;
                dec.reg_write = 1'b1;
                case (op[2:0])
                    3'd0:    dec.alu_code = ALU_ADD;
                    3'd1:    dec.alu_code = ALU_ADDU;
                    3'd2:    dec.alu_code = ALU_SLT;
                    3'd3:    dec.alu_code = ALU_SLTU;
                    3'd4:    dec.alu_code = ALU_ANDI;
                    3'd5:    dec.alu_code = ALU_ORI;
                    3'd6:    dec.alu_code = ALU_XORI;
                    default: begin dec.alu_code = ALU_SLL; dec.src_a = 2'd2; end
                endcase
            end
            6'h23: begin
                dec.alu_code  = ALU_ADD;
                dec.src_b     = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.dst       = rt;
            end
            6'h2B: begin
                dec.alu_code  = ALU_ADD;
                dec.src_b     = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'h04: begin dec.alu_code = ALU_BEQ;  dec.branch = 1'b1; end
            6'h05: begin dec.alu_code = ALU_BNE;  dec.branch = 1'b1; end
            6'h06: begin dec.alu_code = ALU_BLEZ; dec.branch = 1'b1; end
            6'h07: begin dec.alu_code = ALU_BGTZ; dec.branch = 1'b1; end
            6'h01: begin
                dec.branch = 1'b1;
                if (rt == 5'd1)      dec.alu_code = ALU_BGEZ;
                else if (rt == 5'd0) dec.alu_code = ALU_BLTZ;
                else                 dec.illegal  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        ill_d = ill_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d = id_valid ? dec : '0;
            if (id_valid && dec.illegal && (ill_q != {ILL_CNT_W{1'b1}})) begin
                ill_d = ill_q + ILL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            ill_q <= '0;
        end else begin
            ex_q  <= ex_d;
            ill_q <= ill_d;
        end
    end

    assign ex_alu_code  = ex_q.alu_code;
    assign ex_src_a     = ex_q.src_a;
    assign ex_src_b     = ex_q.src_b;
    assign ex_imm       = ex_q.imm;
    assign ex_shamt     = ex_q.shamt;
    assign ex_dst       = ex_q.dst;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_branch    = ex_q.branch;
    assign ex_valid     = ex_q.valid;
    assign ex_illegal   = ex_q.illegal;
    assign ill_count    = ill_q;

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Bench for alu_ctrl_idex: directed vector table, stall/flush/reset sequences, random traffic vs model.
module tb_alu_ctrl_idex;

    typedef struct packed {
        logic [4:0]  code;
        logic [1:0]  sa;
        logic        sb;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [4:0]  dst;
        logic        rw, mr, mw, br, vl, il;
    } ex_t;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        ex_t         exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid, stall, flush;

    logic [4:0]  ex_alu_code, ex_shamt, ex_dst;
    logic [1:0]  ex_src_a;
    logic        ex_src_b, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_valid, ex_illegal;
    logic [31:0] ex_imm;
    logic [7:0]  ill_count;

    logic [4:0]  u2_alu_code, u2_shamt, u2_dst;
    logic [1:0]  u2_src_a;
    logic        u2_src_b, u2_reg_write, u2_mem_read, u2_mem_write, u2_branch, u2_valid, u2_illegal;
    logic [31:0] u2_imm;
    logic [1:0]  u2_ill_count;

    alu_ctrl_idex u_dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ex_alu_code(ex_alu_code), .ex_src_a(ex_src_a),
        .ex_src_b(ex_src_b), .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_valid(ex_valid), .ex_illegal(ex_illegal), .ill_count(ill_count)
    );

    alu_ctrl_idex #(.ILL_CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ex_alu_code(u2_alu_code), .ex_src_a(u2_src_a),
        .ex_src_b(u2_src_b), .ex_imm(u2_imm), .ex_shamt(u2_shamt), .ex_dst(u2_dst),
        .ex_reg_write(u2_reg_write), .ex_mem_read(u2_mem_read), .ex_mem_write(u2_mem_write),
        .ex_branch(u2_branch), .ex_valid(u2_valid), .ex_illegal(u2_illegal), .ill_count(u2_ill_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ex_t  mdl;
    int   ill_cnt;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic ex_t dut_ex();
        return {ex_alu_code, ex_src_a, ex_src_b, ex_imm, ex_shamt, ex_dst,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_valid, ex_illegal};
    endfunction

    function automatic ex_t mk(input logic [4:0] code, input logic [1:0] sa, input logic sb,
                               input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] dst,
                               input logic rw, input logic mr, input logic mw, input logic br,
                               input logic il);
        return {code, sa, sb, imm, sh, dst, rw, mr, mw, br, 1'b1, il};
    endfunction

    // Reference: instruction meaning looked up mnemonic by mnemonic.
    function automatic ex_t model(input logic [31:0] i, input logic v);
        ex_t        e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [31:0] se;
        op = i[31:26]; fn = i[5:0]; rt = i[20:16]; rd = i[15:11];
        se = {{16{i[15]}}, i[15:0]};
        if (!v) return '0;
        e = mk(5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (op == 6'h00) begin
            case (fn)
                6'h20: e = mk(5'd0,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h21: e = mk(5'd21, 0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h22: e = mk(5'd5,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h23: e = mk(5'd22, 0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h24: e = mk(5'd1,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h25: e = mk(5'd3,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h26: e = mk(5'd2,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h27: e = mk(5'd4,  0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h2A: e = mk(5'd19, 0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h2B: e = mk(5'd20, 0, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h00: e = mk(5'd16, 1, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h02: e = mk(5'd17, 1, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h03: e = mk(5'd18, 1, 0, se, i[10:6], rd, 1, 0, 0, 0, 0);
                6'h08: e = mk(5'd9,  0, 0, se, i[10:6], 0,  0, 0, 0, 1, 0);
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: e = mk(5'd0,  0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h09: e = mk(5'd21, 0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0A: e = mk(5'd19, 0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0B: e = mk(5'd20, 0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0C: e = mk(5'd6,  0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0D: e = mk(5'd8,  0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0E: e = mk(5'd7,  0, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h0F: e = mk(5'd16, 2, 1, se, i[10:6], rt, 1, 0, 0, 0, 0);
                6'h23: e = mk(5'd0,  0, 1, se, i[10:6], rt, 1, 1, 0, 0, 0);
                6'h2B: e = mk(5'd0,  0, 1, se, i[10:6], 0,  0, 0, 1, 0, 0);
                6'h04: e = mk(5'd10, 0, 0, se, i[10:6], 0,  0, 0, 0, 1, 0);
                6'h05: e = mk(5'd11, 0, 0, se, i[10:6], 0,  0, 0, 0, 1, 0);
                6'h06: e = mk(5'd14, 0, 0, se, i[10:6], 0,  0, 0, 0, 1, 0);
                6'h07: e = mk(5'd13, 0, 0, se, i[10:6], 0,  0, 0, 0, 1, 0);
                6'h01: begin
                    if (rt == 5'd1) e = mk(5'd12, 0, 0, se, i[10:6], 0, 0, 0, 0, 1, 0);
                    if (rt == 5'd0) e = mk(5'd15, 0, 0, se, i[10:6], 0, 0, 0, 0, 1, 0);
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic check_all(input string nm);
        chk({nm, "_ex"}, 64'(dut_ex()), 64'(mdl));
        chk({nm, "_cnt8"}, 64'(ill_count), 64'((ill_cnt > 255) ? 255 : ill_cnt));
        chk({nm, "_cnt2"}, 64'(u2_ill_count), 64'((ill_cnt > 3) ? 3 : ill_cnt));
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input string nm);
        ex_t nxt;
        id_instr = ins; id_valid = v; stall = st; flush = fl;
        if (fl)      nxt = '0;
        else if (st) nxt = mdl;
        else         nxt = model(ins, v);
        if (!fl && !st && v && nxt.il) ill_cnt++;
        mdl = nxt;
        @(posedge clk);
        #2;
        check_all(nm);
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ins, input ex_t exp);
        vec_t v;
        v.nm = nm; v.ins = ins; v.exp = exp;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [5:0]  ops[19];
        logic [5:0]  fns[15];
        ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h02, 6'h03, 6'h08, 6'h11};
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 18)];
        if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom);
        if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 14)];
        if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        mdl = '0; ill_cnt = 0;

        add_vec("add",    32'h00221820, mk(5'b00000, 0, 0, 32'h00001820, 0,  3, 1, 0, 0, 0, 0));
        add_vec("ori",    32'h34058001, mk(5'b01000, 0, 1, 32'hFFFF8001, 0,  5, 1, 0, 0, 0, 0));
        add_vec("lui",    32'h3C041234, mk(5'b10000, 2, 1, 32'h00001234, 8,  4, 1, 0, 0, 0, 0));
        add_vec("sra",    32'h00031103, mk(5'b10010, 1, 0, 32'h00001103, 4,  2, 1, 0, 0, 0, 0));
        add_vec("sw",     32'hAC220004, mk(5'b00000, 0, 1, 32'h00000004, 0,  0, 0, 0, 1, 0, 0));
        add_vec("bgez",   32'h04210003, mk(5'b01100, 0, 0, 32'h00000003, 0,  0, 0, 0, 0, 1, 0));
        add_vec("regimm2",32'h04220003, mk(5'b00000, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 1));
        add_vec("jr",     32'h03E00008, mk(5'b01001, 0, 0, 32'h00000008, 0,  0, 0, 0, 0, 1, 0));
        add_vec("lw",     32'h8FA80004, mk(5'b00000, 0, 1, 32'h00000004, 0,  8, 1, 1, 0, 0, 0));
        add_vec("nop",    32'h00000000, mk(5'b10000, 1, 0, 32'h00000000, 0,  0, 1, 0, 0, 0, 0));
        add_vec("beq",    32'h1022FFFE, mk(5'b01010, 0, 0, 32'hFFFFFFFE, 31, 0, 0, 0, 0, 1, 0));
        add_vec("sltiu",  32'h2C43FFFF, mk(5'b10100, 0, 1, 32'hFFFFFFFF, 31, 3, 1, 0, 0, 0, 0));
        add_vec("j_ill",  32'h08000000, mk(5'b00000, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 1));
        add_vec("bltz",   32'h0420FFFF, mk(5'b01111, 0, 0, 32'hFFFFFFFF, 31, 0, 0, 0, 0, 1, 0));
        add_vec("fn_ill", 32'h00000001, mk(5'b00000, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 1));

        #2;
        check_all("reset");
        #5 rst_n = 1'b1;

        foreach (vq[k]) begin
            step(vq[k].ins, 1'b1, 1'b0, 1'b0, vq[k].nm);
            chk({vq[k].nm, "_tbl"}, 64'(dut_ex()), 64'(vq[k].exp));
        end
        chk("tbl_illegal_total", 64'(ill_count), 64'd3);

        // Stall holds sra while ID moves on; release loads the waiting instruction.
        step(32'h00031103, 1'b1, 1'b0, 1'b0, "sra_load");
        for (int k = 0; k < 3; k++) begin
            step(32'h00221820 + 32'(k), 1'b1, 1'b1, 1'b0, "stall_hold");
            chk("stall_code", 64'(ex_alu_code), 64'h12);
            chk("stall_shamt", 64'(ex_shamt), 64'd4);
        end
        step(32'h34058001, 1'b1, 1'b0, 1'b0, "stall_release");
        chk("release_code", 64'(ex_alu_code), 64'h08);

        // Flush wins over stall while sw sits in EX.
        step(32'hAC220004, 1'b1, 1'b0, 1'b0, "sw_load");
        step(32'h00221820, 1'b1, 1'b1, 1'b1, "stall_flush");
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_mw", 64'(ex_mem_write), 64'd0);
        step(32'h04220003, 1'b0, 1'b0, 1'b0, "bubble_ill");

        // Asynchronous reset in the middle of a stall, between clock edges.
        step(32'h8FA80004, 1'b1, 1'b0, 1'b0, "pre_rst");
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        mdl = '0; ill_cnt = 0;
        check_all("async_rst");
        #3 rst_n = 1'b1;
        step(32'h00221820, 1'b1, 1'b0, 1'b0, "post_rst_load");

        for (int k = 0; k < 5; k++) step(32'h04220003, 1'b1, 1'b0, 1'b0, "sat_feed");
        chk("sat_cnt2", 64'(u2_ill_count), 64'd3);
        chk("sat_cnt8", 64'(ill_count), 64'd5);

        for (int k = 0; k < 400; k++) begin
            step(rand_instr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
